// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - register writeback queue with in-order drain and youngest-entry forwarding
// Circular FIFO of {addr, data} writebacks feeding a single register file write port.

module reg_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wb_valid_i,
   input  logic [3:0]                 wb_addr_i,
   input  logic [31:0]                wb_data_i,
   output logic                       wb_ready_o,
   input  logic                       hold_i,
   output logic [3:0]                 c_o,
   output logic [31:0]                pc_o,
   output logic                       enable_o,
   input  logic [3:0]                 a_i,
   input  logic [3:0]                 b_i,
   output logic                       fwd_a_hit_o,
   output logic                       fwd_b_hit_o,
   output logic [31:0]                fwd_a_data_o,
   output logic [31:0]                fwd_b_data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [3:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          not_empty;
   logic          push;
   logic          pop;

   assign not_empty  = (count_q != '0);
   // Readiness depends only on registered occupancy, so a same-cycle pop never frees a full queue.
   assign wb_ready_o = (count_q < CW'(DEPTH));
   assign push       = wb_valid_i & wb_ready_o;
   assign pop        = not_empty & ~hold_i;
   assign enable_o   = pop;
   assign count_o    = count_q;
   assign c_o        = not_empty ? addr_q[head_q] : 4'd0;
   assign pc_o       = not_empty ? data_q[head_q] : 32'd0;

   always_comb begin
      head_d  = pop  ? head_q + PW'(1) : head_q;
      tail_d  = push ? tail_q + PW'(1) : tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[tail_q] <= wb_addr_i;
         data_q[tail_q] <= wb_data_i;
      end
   end

   // Scan oldest to youngest so the last match wins; the head being popped is still included.
   always_comb begin
      logic [PW-1:0] idx;
      idx          = '0;
      fwd_a_hit_o  = 1'b0;
      fwd_b_hit_o  = 1'b0;
      fwd_a_data_o = 32'd0;
      fwd_b_data_o = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (addr_q[idx] == a_i) begin
               fwd_a_hit_o  = 1'b1;
               fwd_a_data_o = data_q[idx];
            end
            if (addr_q[idx] == b_i) begin
               fwd_b_hit_o  = 1'b1;
               fwd_b_data_o = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - directed self-checking bench for reg_writeback_queue

module tb_reg_writeback_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic        hold;
   logic [3:0]  c;
   logic [31:0] pc;
   logic        enable;
   logic [3:0]  a, b;
   logic        fwd_a_hit, fwd_b_hit;
   logic [31:0] fwd_a_data, fwd_b_data;
   logic [2:0]  count;

   int checks = 0;
   int fails  = 0;
   logic [35:0] model [$];
   logic [35:0] exp_e;

   reg_writeback_queue #(.DEPTH(4)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .wb_valid_i   (wb_valid),
      .wb_addr_i    (wb_addr),
      .wb_data_i    (wb_data),
      .wb_ready_o   (wb_ready),
      .hold_i       (hold),
      .c_o          (c),
      .pc_o         (pc),
      .enable_o     (enable),
      .a_i          (a),
      .b_i          (b),
      .fwd_a_hit_o  (fwd_a_hit),
      .fwd_b_hit_o  (fwd_b_hit),
      .fwd_a_data_o (fwd_a_data),
      .fwd_b_data_o (fwd_b_data),
      .count_o      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] ad, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_addr  = ad;
      wb_data  = d;
      tick();
      wb_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      hold = 1'b0; a = 4'd0; b = 4'd0;
      #3;
      chk("rst_ready", wb_ready, 1);
      chk("rst_enable", enable, 0);
      chk("rst_count", count, 0);
      chk("rst_c", c, 0);
      chk("rst_pc", pc, 0);
      chk("rst_fwd_a", fwd_a_hit, 0);
      chk("rst_fwd_b_data", fwd_b_data, 0);
      rst_n = 1'b1;

      // single write
      wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hAA;
      #1;
      chk("single_no_passthru_c", c, 0);
      tick();
      wb_valid = 1'b0;
      chk("single_enable", enable, 1);
      chk("single_c", c, 3);
      chk("single_pc", pc, 32'hAA);
      chk("single_count", count, 1);
      tick();
      chk("single_done_count", count, 0);
      chk("single_done_enable", enable, 0);
      chk("single_done_c", c, 0);

      // fill under hold
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) push(4'(i), 32'(i * 8'h11));
      chk("fill_count", count, 4);
      chk("fill_ready", wb_ready, 0);
      chk("fill_enable", enable, 0);
      push(4'd5, 32'h55);
      chk("fill_ignored_count", count, 4);
      chk("fill_hold_c", c, 1);
      hold = 1'b0;
      #1;
      chk("full_pop_ready", wb_ready, 0);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_enable", enable, 1);
         chk("drain_c", c, 4'(i));
         chk("drain_pc", pc, 32'(i * 8'h11));
         tick();
      end
      chk("drain_empty", count, 0);
      chk("drain_enable_off", enable, 0);

      // youngest-entry forwarding, current push excluded
      hold = 1'b1;
      push(4'd5, 32'h10);
      push(4'd5, 32'h20);
      a = 4'd5; b = 4'd6;
      wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
      #1;
      chk("fwd_a_hit", fwd_a_hit, 1);
      chk("fwd_a_data", fwd_a_data, 32'h20);
      chk("fwd_b_hit_pushing", fwd_b_hit, 0);
      chk("fwd_b_data_pushing", fwd_b_data, 0);
      tick();
      wb_valid = 1'b0;
      chk("fwd_b_hit_after", fwd_b_hit, 1);
      chk("fwd_b_data_after", fwd_b_data, 32'h66);
      hold = 1'b0;
      tick(); tick(); tick();
      chk("fwd_drained", count, 0);
      chk("fwd_a_empty", fwd_a_hit, 0);

      // pop-edge forwarding
      hold = 1'b1;
      push(4'd7, 32'h77);
      push(4'd8, 32'h88);
      a = 4'd7;
      hold = 1'b0;
      #1;
      chk("popfwd_enable", enable, 1);
      chk("popfwd_hit", fwd_a_hit, 1);
      chk("popfwd_data", fwd_a_data, 32'h77);
      tick();
      chk("popfwd_hit_after", fwd_a_hit, 0);
      chk("popfwd_c_after", c, 8);
      tick();
      chk("popfwd_drained", count, 0);

      // simultaneous push/pop with wrap-around
      hold = 1'b1;
      push(4'd1, 32'h1);
      push(4'd2, 32'h2);
      model.push_back({4'd1, 32'h1});
      model.push_back({4'd2, 32'h2});
      hold = 1'b0;
      for (int k = 0; k < 12; k++) begin
         wb_valid = 1'b1;
         wb_addr  = 4'((k + 3) % 16);
         wb_data  = 32'(256 + k);
         #1;
         exp_e = model.pop_front();
         chk("pp_c", c, 32'(exp_e[35:32]));
         chk("pp_pc", pc, exp_e[31:0]);
         model.push_back({wb_addr, wb_data});
         tick();
         chk("pp_count", count, 2);
      end
      wb_valid = 1'b0;
      while (model.size() != 0) begin
         exp_e = model.pop_front();
         chk("pp_tail_c", c, 32'(exp_e[35:32]));
         chk("pp_tail_pc", pc, exp_e[31:0]);
         tick();
      end
      chk("pp_drained", count, 0);

      // reset mid-drain
      hold = 1'b1;
      push(4'd10, 32'hA0);
      push(4'd11, 32'hB0);
      push(4'd12, 32'hC0);
      chk("mid_count", count, 3);
      hold = 1'b0;
      #1;
      chk("mid_enable", enable, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_enable", enable, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_c", c, 0);
      chk("mid_rst_ready", wb_ready, 1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_enable", enable, 0);
         tick();
      end
      push(4'd0, 32'h99);
      chk("post_rst_push_count", count, 1);
      chk("post_rst_push_c", c, 0);
      chk("post_rst_push_pc", pc, 32'h99);
      chk("post_rst_push_enable", enable, 1);
      tick();
      chk("post_rst_drained", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
